// File: rtl/water_level_pump_controller_if.sv
// ----------------------------------------------------------------------------
// water_level_pump_controller_if
// Groups the probe inputs, the operator acknowledge and the controller's
// status outputs into one bundle.
//   master : the tank side / operator panel (drives probes and acknowledge)
//   slave  : the pump controller (drives level code, pump, alarm and state)
// Signals
//   probe_low/mid/high  raw level probes, 1 = submerged, asynchronous to clk
//   alarm_ack           operator acknowledge, level-sensitive
//   lvl[1:0]            level code: 00 empty, 01 low, 10 mid, 11 full
//   pump_on             pump enable
//   alarm               fault indicator
//   state[1:0]          controller state: 00 IDLE, 01 FILLING, 10 FAULT
// ----------------------------------------------------------------------------
interface water_level_pump_controller_if;
   logic       probe_low;
   logic       probe_mid;
   logic       probe_high;
   logic       alarm_ack;
   logic [1:0] lvl;
   logic       pump_on;
   logic       alarm;
   logic [1:0] state;

   modport master (
      output probe_low,
      output probe_mid,
      output probe_high,
      output alarm_ack,
      input  lvl,
      input  pump_on,
      input  alarm,
      input  state
   );

   modport slave (
      input  probe_low,
      input  probe_mid,
      input  probe_high,
      input  alarm_ack,
      output lvl,
      output pump_on,
      output alarm,
      output state
   );
endinterface

// File: rtl/water_level_pump_controller.sv
// ----------------------------------------------------------------------------
// water_level_pump_controller
// Runs the tank fill pump from three raw level probes. Each probe passes
// through a two-flop synchroniser and a debounce filter; the filtered probes
// are encoded into a 2-bit level code. A Moore FSM (IDLE / FILLING / FAULT)
// drives the pump with hysteresis (fill from low up to full), a fill timeout
// without level progress, a minimum pump-off time and a latched alarm that
// needs an operator acknowledge with consistent probes to clear.
// Ports
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave side of water_level_pump_controller_if
//          (probes and alarm_ack in; lvl, pump_on, alarm, state out)
// Parameters
//   DEBOUNCE_CYCLES  stable cycles before a probe change is accepted
//   FILL_TIMEOUT     max cycles in FILLING without a level increase
//   MIN_OFF          min cycles the pump stays off after it is switched off
//   CNT_W            counter width, must hold the largest of the above
// ----------------------------------------------------------------------------
module water_level_pump_controller #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int FILL_TIMEOUT    = 1000,
   parameter int MIN_OFF         = 100,
   parameter int CNT_W           = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   water_level_pump_controller_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_FILLING = 2'b01,
      ST_FAULT   = 2'b10
   } state_t;

   // ------------------------------------------------------------------------
   // Input path: synchroniser + debounce per probe, bit order {high,mid,low}
   // ------------------------------------------------------------------------
   logic [2:0] probe_raw;
   logic [2:0] filt_cur;
   logic [2:0] filt_next;

   assign probe_raw = {bus.probe_high, bus.probe_mid, bus.probe_low};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_probe
         logic             sync1_reg;
         logic             sync2_reg;
         logic             filt_reg;
         logic             filt_bit_next;
         logic [CNT_W-1:0] cnt_reg;
         logic [CNT_W-1:0] cnt_next;

         // For a single bit, "synced value changed while differing" means it
         // went back to the filtered value, so equality alone clears the count.
         always_comb begin
            cnt_next      = cnt_reg;
            filt_bit_next = filt_reg;
            if (sync2_reg == filt_reg) begin
               cnt_next = '0;
            end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               filt_bit_next = sync2_reg;
               cnt_next      = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sync1_reg <= 1'b0;
               sync2_reg <= 1'b0;
               filt_reg  <= 1'b0;
               cnt_reg   <= '0;
            end else begin
               sync1_reg <= probe_raw[gi];
               sync2_reg <= sync1_reg;
               filt_reg  <= filt_bit_next;
               cnt_reg   <= cnt_next;
            end
         end

         assign filt_cur[gi]  = filt_reg;
         assign filt_next[gi] = filt_bit_next;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Level encoding: returns {valid, code}. Probes must be submerged from the
   // bottom up; anything else is a wiring/probe fault.
   // ------------------------------------------------------------------------
   function automatic logic [2:0] encode_level(input logic [2:0] f);
      logic [2:0] r;
      case (f)
         3'b000:  r = 3'b1_00;
         3'b001:  r = 3'b1_01;
         3'b011:  r = 3'b1_10;
         3'b111:  r = 3'b1_11;
         default: r = 3'b0_00;
      endcase
      return r;
   endfunction

   logic [2:0] enc_cur;
   logic [2:0] enc_next;
   logic       inconsistent;
   logic [1:0] lvl_reg;
   logic [1:0] lvl_next;
   logic       lvl_inc;

   assign enc_cur      = encode_level(filt_cur);
   assign enc_next     = encode_level(filt_next);
   assign inconsistent = ~enc_cur[2];

   // lvl is loaded from the next filtered value so it moves on the same edge
   // as the filter; an invalid pattern leaves the last good code in place.
   always_comb begin
      lvl_next = lvl_reg;
      if (enc_next[2]) begin
         lvl_next = enc_next[1:0];
      end
   end

   assign lvl_inc = (lvl_next > lvl_reg);

   // ------------------------------------------------------------------------
   // Controller FSM
   // ------------------------------------------------------------------------
   state_t           state_reg;
   state_t           state_next;
   logic [CNT_W-1:0] fill_cnt_reg;
   logic [CNT_W-1:0] fill_cnt_next;
   logic [CNT_W-1:0] off_cnt_reg;
   logic [CNT_W-1:0] off_cnt_next;
   logic             pump_on_reg;
   logic             alarm_reg;
   logic             fill_timeout;

   assign fill_timeout = (fill_cnt_reg == CNT_W'(FILL_TIMEOUT - 1));

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (inconsistent) begin
               state_next = ST_FAULT;
            end else if ((lvl_reg <= 2'b01) && (off_cnt_reg == '0)) begin
               state_next = ST_FILLING;
            end
         end
         ST_FILLING: begin
            // Timeout is checked before "full" so a timeout on the cycle the
            // tank tops out still raises the alarm.
            if (inconsistent) begin
               state_next = ST_FAULT;
            end else if (fill_timeout) begin
               state_next = ST_FAULT;
            end else if (lvl_reg == 2'b11) begin
               state_next = ST_IDLE;
            end
         end
         ST_FAULT: begin
            if (bus.alarm_ack && !inconsistent) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Min-off counter: reloaded whenever the pump is switched off or the alarm
   // is cleared, otherwise runs down (and saturates) while not filling.
   always_comb begin
      off_cnt_next = off_cnt_reg;
      if ((state_reg == ST_FILLING && state_next != ST_FILLING) ||
          (state_reg == ST_FAULT && state_next == ST_IDLE)) begin
         off_cnt_next = CNT_W'(MIN_OFF);
      end else if (state_reg != ST_FILLING && off_cnt_reg != '0) begin
         off_cnt_next = off_cnt_reg - 1'b1;
      end
   end

   // Fill counter measures time since entry or since the last level rise;
   // a falling level does not restart it.
   always_comb begin
      fill_cnt_next = fill_cnt_reg;
      if (state_next == ST_FILLING) begin
         if (state_reg != ST_FILLING || lvl_inc) begin
            fill_cnt_next = '0;
         end else begin
            fill_cnt_next = fill_cnt_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         lvl_reg      <= 2'b00;
         fill_cnt_reg <= '0;
         off_cnt_reg  <= CNT_W'(MIN_OFF);
         pump_on_reg  <= 1'b0;
         alarm_reg    <= 1'b0;
      end else begin
         state_reg    <= state_next;
         lvl_reg      <= lvl_next;
         fill_cnt_reg <= fill_cnt_next;
         off_cnt_reg  <= off_cnt_next;
         pump_on_reg  <= (state_next == ST_FILLING);
         alarm_reg    <= (state_next == ST_FAULT);
      end
   end

   assign bus.lvl     = lvl_reg;
   assign bus.pump_on = pump_on_reg;
   assign bus.alarm   = alarm_reg;
   assign bus.state   = state_reg;

endmodule

// File: tb/tb_water_level_pump_controller.sv
// ----------------------------------------------------------------------------
// tb_water_level_pump_controller
// Directed test of the pump controller with short timing parameters
// (debounce 4, fill timeout 20, min-off 8). Inputs are driven and outputs
// sampled 1 ns after the rising clock edge; "En" in comments means n rising
// edges after the last reset release.
// ----------------------------------------------------------------------------
module tb_water_level_pump_controller;
   localparam int DEB  = 4;
   localparam int TMO  = 20;
   localparam int MOFF = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   water_level_pump_controller_if bus ();

   water_level_pump_controller #(
      .DEBOUNCE_CYCLES (DEB),
      .FILL_TIMEOUT    (TMO),
      .MIN_OFF         (MOFF),
      .CNT_W           (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_probes(input logic [2:0] p);
      bus.probe_high = p[2];
      bus.probe_mid  = p[1];
      bus.probe_low  = p[0];
   endtask

   // Reset for two clocks, release 1 ns after a rising edge (that edge is E0).
   task automatic apply_reset(input logic [2:0] p);
      rst_n         = 1'b0;
      bus.alarm_ack = 1'b0;
      set_probes(p);
      step(2);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.alarm_ack = 1'b0;
      set_probes(3'b000);

      // ---- 1: reset values, pump starts 9 clocks after release ------------
      rst_n = 1'b0;
      step(2);
      check("t1_rst_lvl",   bus.lvl,     2'b00);
      check("t1_rst_pump",  bus.pump_on, 1'b0);
      check("t1_rst_alarm", bus.alarm,   1'b0);
      check("t1_rst_state", bus.state,   2'b00);
      rst_n = 1'b1;
      step(8);                                         // E8
      check("t1_pump_e8",   bus.pump_on, 1'b0);
      step(1);                                         // E9
      check("t1_pump_e9",   bus.pump_on, 1'b1);
      check("t1_state_e9",  bus.state,   2'b01);

      // ---- 2: fill steps 001 / 011 / 111, lvl 6 clocks after each edge -----
      set_probes(3'b001);
      step(5);
      check("t2_lvl01_pre",  bus.lvl, 2'b00);
      step(1);
      check("t2_lvl01",      bus.lvl, 2'b01);
      step(4);
      set_probes(3'b011);
      step(5);
      check("t2_lvl10_pre",  bus.lvl, 2'b01);
      step(1);
      check("t2_lvl10",      bus.lvl, 2'b10);
      check("t2_pump_at10",  bus.pump_on, 1'b1);
      step(4);
      set_probes(3'b111);
      step(5);
      check("t2_lvl11_pre",  bus.lvl, 2'b10);
      step(1);
      check("t2_lvl11",      bus.lvl, 2'b11);
      check("t2_pump_at11",  bus.pump_on, 1'b1);
      step(1);
      check("t2_pump_off",   bus.pump_on, 1'b0);
      check("t2_state_idle", bus.state, 2'b00);

      // ---- 3: 3-cycle mid glitch rejected, 4-cycle hold accepted ----------
      apply_reset(3'b001);
      step(12);                                        // E12
      check("t3_lvl_start", bus.lvl, 2'b01);
      check("t3_pump",      bus.pump_on, 1'b1);
      set_probes(3'b011);
      step(3);
      set_probes(3'b001);
      step(7);                                         // E22
      check("t3_glitch",    bus.lvl, 2'b01);
      set_probes(3'b011);
      step(4);
      set_probes(3'b001);
      step(1);                                         // E27
      check("t3_hold_pre",  bus.lvl, 2'b01);
      step(1);                                         // E28
      check("t3_hold",      bus.lvl, 2'b10);

      // ---- 4: fill timeout, acknowledge, min-off restart -------------------
      apply_reset(3'b001);
      step(9);                                         // E9
      check("t4_fill",      bus.pump_on, 1'b1);
      step(19);                                        // E28
      check("t4_pre_to",    bus.state, 2'b01);
      step(1);                                         // E29
      check("t4_to_pump",   bus.pump_on, 1'b0);
      check("t4_to_alarm",  bus.alarm,   1'b1);
      check("t4_to_state",  bus.state,   2'b10);
      check("t4_to_lvl",    bus.lvl,     2'b01);
      bus.alarm_ack = 1'b1;
      step(1);                                         // E30
      bus.alarm_ack = 1'b0;
      check("t4_ack_state", bus.state, 2'b00);
      check("t4_ack_alarm", bus.alarm, 1'b0);
      step(8);                                         // E38
      check("t4_restart_pre", bus.pump_on, 1'b0);
      step(1);                                         // E39
      check("t4_restart",   bus.pump_on, 1'b1);

      // ---- 5: inconsistent probes, ack ignored until consistent ------------
      apply_reset(3'b001);
      step(8);                                         // E8
      set_probes(3'b101);
      step(6);                                         // E14
      check("t5_lvl_hold",  bus.lvl,   2'b01);
      check("t5_pre_fault", bus.state, 2'b01);
      step(1);                                         // E15
      check("t5_fault",     bus.state, 2'b10);
      check("t5_alarm",     bus.alarm, 1'b1);
      check("t5_lvl_keep",  bus.lvl,   2'b01);
      bus.alarm_ack = 1'b1;
      step(3);                                         // E18
      check("t5_ack_ign",   bus.state, 2'b10);
      set_probes(3'b111);
      step(6);                                         // E24
      check("t5_lvl_full",  bus.lvl,   2'b11);
      check("t5_still_flt", bus.alarm, 1'b1);
      step(1);                                         // E25
      check("t5_cleared",   bus.state, 2'b00);
      check("t5_alarm_off", bus.alarm, 1'b0);
      bus.alarm_ack = 1'b0;

      // ---- 6: asynchronous reset mid-fill ---------------------------------
      apply_reset(3'b001);
      step(12);                                        // E12
      check("t6_filling",   bus.pump_on, 1'b1);
      check("t6_lvl",       bus.lvl,     2'b01);
      rst_n = 1'b0;
      #1;
      check("t6_rst_pump",  bus.pump_on, 1'b0);
      check("t6_rst_lvl",   bus.lvl,     2'b00);
      check("t6_rst_state", bus.state,   2'b00);
      check("t6_rst_alarm", bus.alarm,   1'b0);
      step(2);
      rst_n = 1'b1;
      step(8);                                         // E8
      check("t6_minoff",    bus.pump_on, 1'b0);
      step(1);                                         // E9
      check("t6_restart",   bus.pump_on, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
